// File: rtl/common_dffram_wrctrl.sv
// -----------------------------------------------------------------------------
// common_dffram_wrctrl
//
// Write-port initiator for the DFF-based RAM family (2-address, bit-write-
// enable, 2-read). Drives RAM port A and arbitrates between a valid/ready
// client write stream and an internal clear engine that sweeps every address
// with a fill word (bulk invalidate for tag / predictor / regfile arrays).
//
// Parameters
//   RAM_DATA_WIDTH : word width, equals the RAM data width
//   RAM_ADDR_WIDTH : address width, RAM depth is 2**RAM_ADDR_WIDTH
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   req_valid/req_ready     : client write handshake
//   req_addr/wmask/data     : client write address, per-bit enable, data
//   clr_start, clr_value    : start pulse and fill word for a full clear
//   clr_busy, clr_done      : sweep in progress / one-cycle completion pulse
//   ram_addra/ena/wea/dina  : registered RAM port A drive
//
// Build option
//   COMMON_DFFRAM_WRCTRL_CLEAR_ON_RESET_EN : when defined, reset lands in the
//   clear state with a zero fill so the array is swept automatically after
//   every reset. When undefined, reset lands idle.
// -----------------------------------------------------------------------------
module common_dffram_wrctrl #(
    parameter int RAM_DATA_WIDTH = 1,
    parameter int RAM_ADDR_WIDTH = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [RAM_ADDR_WIDTH-1:0] req_addr,
    input  logic [RAM_DATA_WIDTH-1:0] req_wmask,
    input  logic [RAM_DATA_WIDTH-1:0] req_data,
    input  logic                      clr_start,
    input  logic [RAM_DATA_WIDTH-1:0] clr_value,
    output logic                      clr_busy,
    output logic                      clr_done,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addra,
    output logic                      ram_ena,
    output logic [RAM_DATA_WIDTH-1:0] ram_wea,
    output logic [RAM_DATA_WIDTH-1:0] ram_dina
);

    localparam int CNT_W = RAM_ADDR_WIDTH + 1;

    localparam logic [RAM_DATA_WIDTH-1:0] DATA_ONES = {RAM_DATA_WIDTH{1'b1}};
    localparam logic [RAM_DATA_WIDTH-1:0] DATA_ZERO = {RAM_DATA_WIDTH{1'b0}};
    localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_ZERO = {RAM_ADDR_WIDTH{1'b0}};
    localparam logic [CNT_W-1:0]          CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]          CNT_ONE   = {{RAM_ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                      state_q;
    // Sweep counter holds the next address to write; the extra MSB sets once
    // the last address has been issued and marks the end of the sweep.
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_d;
    logic [RAM_DATA_WIDTH-1:0]   fill_q;
    logic [RAM_ADDR_WIDTH-1:0]   ram_addra_q;
    logic                        ram_ena_q;
    logic [RAM_DATA_WIDTH-1:0]   ram_wea_q;
    logic [RAM_DATA_WIDTH-1:0]   ram_dina_q;
    logic                        clr_busy_q;
    logic                        clr_done_q;

    assign ram_addra = ram_addra_q;
    assign ram_ena   = ram_ena_q;
    assign ram_wea   = ram_wea_q;
    assign ram_dina  = ram_dina_q;
    assign clr_busy  = clr_busy_q;
    assign clr_done  = clr_done_q;

    // Incremented sweep counter for the next clear cycle.
    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
    end

    // Client ready: only idle accepts writes, and a clear start takes priority.
    always_comb begin
        req_ready = 1'b0;
        case (state_q)
            S_IDLE:  req_ready = !clr_start;
            S_CLEAR: req_ready = 1'b0;
            default: req_ready = 1'b0;
        endcase
    end

    // Arbitration FSM with registered RAM port drive and clear status.
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef COMMON_DFFRAM_WRCTRL_CLEAR_ON_RESET_EN
            state_q    <= S_CLEAR;
            clr_busy_q <= 1'b1;
`else
            state_q    <= S_IDLE;
            clr_busy_q <= 1'b0;
`endif
            cnt_q       <= CNT_ZERO;
            fill_q      <= DATA_ZERO;
            ram_addra_q <= ADDR_ZERO;
            ram_ena_q   <= 1'b0;
            ram_wea_q   <= DATA_ZERO;
            ram_dina_q  <= DATA_ZERO;
            clr_done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    clr_done_q <= 1'b0;
                    if (clr_start) begin
                        // Address 0 is written on the accepting edge so the
                        // first sweep write lands in the very next cycle; the
                        // counter therefore resumes at address 1.
                        state_q     <= S_CLEAR;
                        fill_q      <= clr_value;
                        cnt_q       <= CNT_ONE;
                        clr_busy_q  <= 1'b1;
                        ram_ena_q   <= 1'b1;
                        ram_addra_q <= ADDR_ZERO;
                        ram_wea_q   <= DATA_ONES;
                        ram_dina_q  <= clr_value;
                    end else if (req_valid) begin
                        // req_ready is high here, so this is a handshake.
                        clr_busy_q  <= 1'b0;
                        ram_ena_q   <= 1'b1;
                        ram_addra_q <= req_addr;
                        ram_wea_q   <= req_wmask;
                        ram_dina_q  <= req_data;
                    end else begin
                        clr_busy_q  <= 1'b0;
                        ram_ena_q   <= 1'b0;
                        ram_wea_q   <= DATA_ZERO;
                    end
                end
                S_CLEAR: begin
                    if (cnt_q[RAM_ADDR_WIDTH]) begin
                        // Last address already issued: finish the sweep.
                        state_q    <= S_IDLE;
                        cnt_q      <= CNT_ZERO;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                        ram_ena_q  <= 1'b0;
                        ram_wea_q  <= DATA_ZERO;
                    end else begin
                        cnt_q       <= cnt_d;
                        clr_busy_q  <= 1'b1;
                        clr_done_q  <= 1'b0;
                        ram_ena_q   <= 1'b1;
                        ram_addra_q <= cnt_q[RAM_ADDR_WIDTH-1:0];
                        ram_wea_q   <= DATA_ONES;
                        ram_dina_q  <= fill_q;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    cnt_q      <= CNT_ZERO;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                    ram_ena_q  <= 1'b0;
                    ram_wea_q  <= DATA_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_common_dffram_wrctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for common_dffram_wrctrl (RAM_ADDR_WIDTH=3, width 8).
// A transaction-level model predicts the RAM port and clear status each cycle;
// a bench-side RAM applies the issued writes so readback can be checked
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_common_dffram_wrctrl;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wmask;
    logic [DW-1:0] req_data;
    logic          clr_start;
    logic [DW-1:0] clr_value;
    logic          clr_busy;
    logic          clr_done;
    logic [AW-1:0] ram_addra;
    logic          ram_ena;
    logic [DW-1:0] ram_wea;
    logic [DW-1:0] ram_dina;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    common_dffram_wrctrl #(
        .RAM_DATA_WIDTH(DW),
        .RAM_ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wmask (req_wmask),
        .req_data  (req_data),
        .clr_start (clr_start),
        .clr_value (clr_value),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .ram_addra (ram_addra),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_dina  (ram_dina)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench RAM: applies the write present on port A during each cycle.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (ram_ena === 1'b1) mem[ram_addra] = (mem[ram_addra] & ~ram_wea) | (ram_dina & ram_wea);
        end
    end

    // Transaction model plus per-cycle compare.
    initial begin : model
        logic          r, s, v;
        logic [AW-1:0] a;
        logic [DW-1:0] wm, d, cv;
        bit            m_on;
        bit            m_clear;
        int            m_next;
        int            m_left;
        logic [DW-1:0] m_fill;
        logic          e_ena, e_busy, e_done;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wea, e_dina;
        m_on = 1'b0; m_clear = 1'b0; m_next = 0; m_left = 0; m_fill = 8'h00;
        e_ena = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_addr = 3'd0; e_wea = 8'h00; e_dina = 8'h00;
        forever begin
            @(posedge clk);
            r = reset; s = clr_start; v = req_valid; a = req_addr;
            wm = req_wmask; d = req_data; cv = clr_value;
            if (r === 1'b1) begin
                m_on = 1'b1; m_clear = 1'b0;
                e_ena = 1'b0; e_busy = 1'b0; e_done = 1'b0;
                e_addr = 3'd0; e_wea = 8'h00; e_dina = 8'h00;
            end else if (m_on) begin
                e_done = 1'b0;
                if (m_clear) begin
                    if (m_left > 0) begin
                        e_ena = 1'b1; e_addr = m_next[AW-1:0]; e_wea = 8'hFF; e_dina = m_fill;
                        m_next++; m_left--; e_busy = 1'b1;
                    end else begin
                        e_ena = 1'b0; e_busy = 1'b0; e_done = 1'b1; m_clear = 1'b0;
                    end
                end else if (s === 1'b1) begin
                    m_clear = 1'b1; m_fill = cv; m_next = 1; m_left = DEPTH - 1;
                    e_ena = 1'b1; e_addr = 3'd0; e_wea = 8'hFF; e_dina = cv; e_busy = 1'b1;
                end else if (v === 1'b1) begin
                    e_ena = 1'b1; e_addr = a; e_wea = wm; e_dina = d; e_busy = 1'b0;
                end else begin
                    e_ena = 1'b0; e_busy = 1'b0;
                end
            end
            #1;
            if (m_on) begin
                chk("ram_ena", 32'(ram_ena), 32'(e_ena));
                chk("clr_busy", 32'(clr_busy), 32'(e_busy));
                chk("clr_done", 32'(clr_done), 32'(e_done));
                chk("req_ready", 32'(req_ready), 32'(!m_clear && (clr_start !== 1'b1)));
                if (e_ena || r) begin
                    chk("ram_addra", 32'(ram_addra), 32'(e_addr));
                    chk("ram_wea", 32'(ram_wea), 32'(e_wea));
                    chk("ram_dina", 32'(ram_dina), 32'(e_dina));
                end
            end
        end
    end

    // Single client write; holds the request until accepted.
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] m, input logic [DW-1:0] d);
        int k;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_wmask = m; req_data = d;
        #1;
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(negedge clk); #1; k++;
        end
        if (k >= 50) chk("send_timeout", 32'h1, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Run a clear with the given fill, optionally re-pulsing clr_start
    // mid-sweep, and count busy cycles and done pulses.
    task automatic run_clear(input logic [DW-1:0] fill, input bit restart, input string tag);
        int busy_n, done_n, done_at;
        @(negedge clk);
        clr_start = 1'b1; clr_value = fill;
        @(negedge clk);
        clr_start = 1'b0; clr_value = 8'h00;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int i = 0; i < 14; i++) begin
            if (clr_busy === 1'b1) busy_n++;
            if (clr_done === 1'b1) begin done_n++; done_at = i; end
            if (restart && i == 2) clr_start = 1'b1;
            else clr_start = 1'b0;
            @(negedge clk);
        end
        clr_start = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
        chk({tag, "_done_cycle"}, 32'(done_at), 32'd8);
    endtask

    initial begin
        int k;
        reset = 1'b1; req_valid = 1'b0; req_addr = 3'd0; req_wmask = 8'h00; req_data = 8'h00;
        clr_start = 1'b0; clr_value = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ram_ena", 32'(ram_ena), 32'h0);
        chk("rst_ram_addra", 32'(ram_addra), 32'h0);
        chk("rst_ram_wea", 32'(ram_wea), 32'h0);
        chk("rst_ram_dina", 32'(ram_dina), 32'h0);
        chk("rst_clr_busy", 32'(clr_busy), 32'h0);
        chk("rst_clr_done", 32'(clr_done), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);

        // Single full-mask write, then partial mask, then empty mask.
        send(3'd5, 8'hFF, 8'hA5);
        @(negedge clk);
        chk("single_write", 32'(mem[5]), 32'hA5);
        send(3'd5, 8'h0F, 8'h3C);
        @(negedge clk);
        chk("partial_mask", 32'(mem[5]), 32'hAC);
        send(3'd5, 8'h00, 8'hFF);
        @(negedge clk);
        chk("zero_mask", 32'(mem[5]), 32'hAC);

        // Back-to-back writes, one per cycle.
        @(negedge clk);
        req_valid = 1'b1; req_wmask = 8'hFF; req_addr = 3'd1; req_data = 8'h10;
        @(negedge clk);
        req_addr = 3'd3; req_data = 8'h30;
        @(negedge clk);
        req_addr = 3'd6; req_data = 8'h60;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_1", 32'(mem[1]), 32'h10);
        chk("b2b_3", 32'(mem[3]), 32'h30);
        chk("b2b_6", 32'(mem[6]), 32'h60);

        // Full clear with 0x11.
        run_clear(8'h11, 1'b0, "clear");
        for (int i = 0; i < DEPTH; i++) chk($sformatf("clear_word%0d", i), 32'(mem[i]), 32'h11);

        // Collision: clear start and client request in the same cycle.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 3'd2; req_wmask = 8'hFF; req_data = 8'h77;
        clr_start = 1'b1; clr_value = 8'h55;
        #1;
        chk("collide_ready_low", 32'(req_ready), 32'h0);
        @(negedge clk);
        clr_start = 1'b0;
        k = 1;
        #1;
        while (req_ready !== 1'b1 && k < 50) begin
            @(negedge clk); #1; k++;
        end
        chk("collide_accept_cycle", 32'(k), 32'd9);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("collide_addr2", 32'(mem[2]), 32'h77);
        chk("collide_addr3", 32'(mem[3]), 32'h55);

        // Restart request during a sweep is ignored.
        run_clear(8'h33, 1'b1, "restart");
        for (int i = 0; i < DEPTH; i++) chk($sformatf("restart_word%0d", i), 32'(mem[i]), 32'h33);

        // Reset mid-sweep while address 3 is being written.
        @(negedge clk);
        clr_start = 1'b1; clr_value = 8'h44;
        @(negedge clk);
        clr_start = 1'b0;
        k = 0;
        while (!(ram_ena === 1'b1 && ram_addra == 3'd3) && k < 20) begin
            @(negedge clk); k++;
        end
        chk("midreset_found_addr3", 32'(k < 20), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_ena", 32'(ram_ena), 32'h0);
        chk("midreset_busy", 32'(clr_busy), 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("midreset_stays_idle", 32'(clr_busy), 32'h0);
        for (int i = 0; i < 3; i++) chk($sformatf("midreset_fill%0d", i), 32'(mem[i]), 32'h44);
        for (int i = 4; i < DEPTH; i++) chk($sformatf("midreset_old%0d", i), 32'(mem[i]), 32'h33);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop if the run ever stalls.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
